// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku board checker.
//   cell_t    : one 4-bit board cell (0 empty, 1-9 digit, 10-15 illegal)
//   board_t   : 9x9 grid of cells indexed [row][col]
//   state_t   : checker FSM states
//   pass_t    : encoding of the scan pass that found the first offence
//   box_coord : maps (group, element) of the box pass to (row, col)
package sudoku_pkg;

    localparam int N = 9;
    localparam logic [3:0] NO_COORD = 4'hF;

    typedef logic [3:0] cell_t;
    typedef cell_t [N-1:0][N-1:0] board_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROWS   = 3'd1,
        COLS   = 3'd2,
        BOXES  = 3'd3,
        REPORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PASS_NONE  = 2'd0,
        PASS_ROWS  = 2'd1,
        PASS_COLS  = 2'd2,
        PASS_BOXES = 2'd3
    } pass_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } coord_t;

    // Box g (0..8, row-major over the 3x3 boxes), element e (row-major inside the box).
    function automatic coord_t box_coord(input logic [3:0] g, input logic [3:0] e);
        coord_t c;
        c.row = (4'd3 * (g / 4'd3)) + (e / 4'd3);
        c.col = (4'd3 * (g % 4'd3)) + (e % 4'd3);
        return c;
    endfunction

endpackage

// File: rtl/sudoku_scan_addr.sv
// Scan address generator: pass / group / element counters and their
// mapping to a board coordinate.
//   clock, reset_n : clock and async active-low reset
//   clear          : return counters to the first cell of the ROWS pass
//   advance        : step to the next cell (one cell per cycle)
//   pass           : current pass (ROWS, COLS, BOXES)
//   row, col       : coordinate of the current cell
//   first_elem     : current cell is element 0 of its group
//   last_in_pass   : current cell is the last one of the current pass
//   last_cell      : current cell is the last cell of the whole scan
module sudoku_scan_addr
    import sudoku_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       advance,
    output pass_t      pass,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       first_elem,
    output logic       last_in_pass,
    output logic       last_cell
);

    pass_t      pass_r;
    logic [3:0] g_r;
    logic [3:0] e_r;
    coord_t     box_s;

    // Counter stepping: element fastest, then group, then pass.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pass_r <= PASS_ROWS;
            g_r    <= 4'd0;
            e_r    <= 4'd0;
        end else if (clear) begin
            pass_r <= PASS_ROWS;
            g_r    <= 4'd0;
            e_r    <= 4'd0;
        end else if (advance) begin
            if (e_r == 4'd8) begin
                e_r <= 4'd0;
                if (g_r == 4'd8) begin
                    g_r <= 4'd0;
                    case (pass_r)
                        PASS_ROWS: pass_r <= PASS_COLS;
                        PASS_COLS: pass_r <= PASS_BOXES;
                        default:   pass_r <= PASS_ROWS;
                    endcase
                end else begin
                    g_r <= g_r + 4'd1;
                end
            end else begin
                e_r <= e_r + 4'd1;
            end
        end
    end

    // Map (pass, group, element) to the board coordinate being read.
    always_comb begin
        box_s = box_coord(g_r, e_r);
        row   = g_r;
        col   = e_r;
        case (pass_r)
            PASS_ROWS: begin
                row = g_r;
                col = e_r;
            end
            PASS_COLS: begin
                row = e_r;
                col = g_r;
            end
            PASS_BOXES: begin
                row = box_s.row;
                col = box_s.col;
            end
            default: begin
                row = g_r;
                col = e_r;
            end
        endcase
    end

    assign pass         = pass_r;
    assign first_elem   = (e_r == 4'd0);
    assign last_in_pass = (g_r == 4'd8) && (e_r == 4'd8);
    assign last_cell    = last_in_pass && (pass_r == PASS_BOXES);

endmodule

// File: rtl/sudoku_checker.sv
// Sudoku board checker: snapshots the board on start, scans rows, columns
// and boxes one cell per cycle (243 cycles), then reports the verdict.
//   clock, reset_n        : clock and async active-low reset
//   start                 : request a check (honoured only in IDLE)
//   game_board            : board under test, [row][col]
//   busy                  : scan in progress
//   done                  : one-cycle pulse, results valid from this cycle
//   valid                 : no duplicate digit and no illegal cell
//   complete              : valid and no empty cell
//   conflict_row/col      : first offending cell in scan order, 4'hF if none
//   conflict_pass         : pass of the first offence (0 none, 1 rows, 2 cols, 3 boxes)
module sudoku_checker
    import sudoku_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  board_t     game_board,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       complete,
    output logic [3:0] conflict_row,
    output logic [3:0] conflict_col,
    output logic [1:0] conflict_pass
);

    state_t     state_r;
    board_t     snap_r;
    logic [8:0] seen_r;
    logic       has_empty_r;
    logic       found_r;
    logic [3:0] first_row_r;
    logic [3:0] first_col_r;
    pass_t      first_pass_r;

    logic       accept_s;
    logic       scanning_s;
    pass_t      pass_s;
    logic [3:0] row_s;
    logic [3:0] col_s;
    logic       first_elem_s;
    logic       last_in_pass_s;
    logic       last_cell_s;
    cell_t      cell_s;
    logic [8:0] seen_base_s;
    logic [8:0] seen_next_s;
    logic       is_empty_s;
    logic       bad_s;

    assign accept_s   = (state_r == IDLE) && start;
    assign scanning_s = (state_r == ROWS) || (state_r == COLS) || (state_r == BOXES);

    sudoku_scan_addr u_addr (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (accept_s),
        .advance      (scanning_s),
        .pass         (pass_s),
        .row          (row_s),
        .col          (col_s),
        .first_elem   (first_elem_s),
        .last_in_pass (last_in_pass_s),
        .last_cell    (last_cell_s)
    );

    // Classify the current cell against the group's seen mask.
    always_comb begin
        cell_s      = snap_r[row_s][col_s];
        seen_base_s = first_elem_s ? 9'd0 : seen_r;
        seen_next_s = seen_base_s;
        is_empty_s  = 1'b0;
        bad_s       = 1'b0;
        if (cell_s == 4'd0) begin
            is_empty_s = 1'b1;
        end else if (cell_s <= 4'd9) begin
            if (seen_base_s[cell_s - 4'd1]) begin
                bad_s = 1'b1;
            end else begin
                seen_next_s = seen_base_s | (9'd1 << (cell_s - 4'd1));
            end
        end else begin
            // Illegal code: counts as a conflict, mask left untouched.
            bad_s = 1'b1;
        end
    end

    // Checker FSM with snapshot, accumulators and registered results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            snap_r        <= '0;
            seen_r        <= 9'd0;
            has_empty_r   <= 1'b0;
            found_r       <= 1'b0;
            first_row_r   <= NO_COORD;
            first_col_r   <= NO_COORD;
            first_pass_r  <= PASS_NONE;
            busy          <= 1'b0;
            done          <= 1'b0;
            valid         <= 1'b0;
            complete      <= 1'b0;
            conflict_row  <= NO_COORD;
            conflict_col  <= NO_COORD;
            conflict_pass <= 2'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r       <= ROWS;
                        snap_r        <= game_board;
                        seen_r        <= 9'd0;
                        has_empty_r   <= 1'b0;
                        found_r       <= 1'b0;
                        first_row_r   <= NO_COORD;
                        first_col_r   <= NO_COORD;
                        first_pass_r  <= PASS_NONE;
                        busy          <= 1'b1;
                        valid         <= 1'b0;
                        complete      <= 1'b0;
                        conflict_row  <= NO_COORD;
                        conflict_col  <= NO_COORD;
                        conflict_pass <= 2'd0;
                    end
                end
                ROWS, COLS, BOXES: begin
                    seen_r <= seen_next_s;
                    if (is_empty_s) begin
                        has_empty_r <= 1'b1;
                    end
                    // Only the first offence in scan order is recorded.
                    if (bad_s && !found_r) begin
                        found_r      <= 1'b1;
                        first_row_r  <= row_s;
                        first_col_r  <= col_s;
                        first_pass_r <= pass_s;
                    end
                    if (last_cell_s) begin
                        state_r <= REPORT;
                    end else if (last_in_pass_s) begin
                        state_r <= (state_r == ROWS) ? COLS : BOXES;
                    end
                end
                REPORT: begin
                    state_r       <= IDLE;
                    busy          <= 1'b0;
                    done          <= 1'b1;
                    valid         <= ~found_r;
                    complete      <= ~found_r & ~has_empty_r;
                    conflict_row  <= first_row_r;
                    conflict_col  <= first_col_r;
                    conflict_pass <= first_pass_r;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_checker.sv
// Directed bench for sudoku_checker with a scoreboard of expected verdicts
// produced by a behavioural reference model of the board rules.
module tb_sudoku_checker;
    import sudoku_pkg::*;

    typedef struct packed {
        logic       valid;
        logic       complete;
        logic [3:0] row;
        logic [3:0] col;
        logic [1:0] pass;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    board_t     game_board;
    logic       busy;
    logic       done;
    logic       valid;
    logic       complete;
    logic [3:0] conflict_row;
    logic [3:0] conflict_col;
    logic [1:0] conflict_pass;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    sudoku_checker dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .game_board    (game_board),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .complete      (complete),
        .conflict_row  (conflict_row),
        .conflict_col  (conflict_col),
        .conflict_pass (conflict_pass)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: straightforward rule scan over rows, cols, boxes.
    function automatic exp_t model(input board_t b);
        exp_t r;
        logic [8:0] seen;
        logic found, empty, bad;
        int rr, cc, v;
        found = 1'b0; empty = 1'b0;
        r.row = 4'hF; r.col = 4'hF; r.pass = 2'd0;
        for (int p = 1; p <= 3; p++) begin
            for (int g = 0; g < 9; g++) begin
                seen = 9'd0;
                for (int e = 0; e < 9; e++) begin
                    if (p == 1) begin rr = g; cc = e; end
                    else if (p == 2) begin rr = e; cc = g; end
                    else begin rr = 3 * (g / 3) + e / 3; cc = 3 * (g % 3) + e % 3; end
                    v = int'(b[rr][cc]);
                    bad = 1'b0;
                    if (v == 0) empty = 1'b1;
                    else if (v <= 9) begin
                        if (seen[v-1]) bad = 1'b1;
                        else seen[v-1] = 1'b1;
                    end else bad = 1'b1;
                    if (bad && !found) begin
                        found = 1'b1;
                        r.row = 4'(rr); r.col = 4'(cc); r.pass = 2'(p);
                    end
                end
            end
        end
        r.valid = ~found;
        r.complete = ~found & ~empty;
        return r;
    endfunction

    function automatic board_t solved_board();
        board_t b;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                b[r][c] = 4'(((r * 3 + r / 3 + c) % 9) + 1);
        return b;
    endfunction

    // Start a check, optionally pulse start / change the bus mid-scan,
    // then wait (bounded) for done and compare against the scoreboard.
    task automatic run_check(input string name, input board_t b, input int pulse_at,
                             input int change_at, input board_t alt);
        int   cyc;
        logic got;
        exp_t e;
        @(negedge clock);
        game_board = b;
        start = 1'b1;
        sb.push_back(model(b));
        @(posedge clock);
        #1;
        start = 1'b0;
        check({name, "/busy"}, 32'(busy), 32'd1);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(posedge clock);
            cyc++;
            #1;
            start = (pulse_at != 0) && (cyc == pulse_at);
            if (change_at != 0 && cyc == change_at) game_board = alt;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        check({name, "/latency"}, 32'(cyc), 32'd244);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({name, "/valid"}, 32'(valid), 32'(e.valid));
            check({name, "/complete"}, 32'(complete), 32'(e.complete));
            check({name, "/row"}, 32'(conflict_row), 32'(e.row));
            check({name, "/col"}, 32'(conflict_col), 32'(e.col));
            check({name, "/pass"}, 32'(conflict_pass), 32'(e.pass));
            check({name, "/busy_at_done"}, 32'(busy), 32'd0);
            @(posedge clock);
            #1;
            check({name, "/done_pulse"}, 32'(done), 32'd0);
            check({name, "/hold"}, 32'(valid), 32'(e.valid));
        end else begin
            sb.delete();
            check({name, "/done_seen"}, 32'(got), 32'd1);
        end
    endtask

    initial begin
        board_t zero_b, solved_b, part_b, b;
        logic saw_done;

        zero_b   = '0;
        solved_b = solved_board();

        reset_n = 1'b0;
        start = 1'b0;
        game_board = zero_b;
        repeat (3) @(posedge clock);
        #1;
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/done", 32'(done), 32'd0);
        check("rst/valid", 32'(valid), 32'd0);
        check("rst/complete", 32'(complete), 32'd0);
        check("rst/row", 32'(conflict_row), 32'hF);
        check("rst/col", 32'(conflict_col), 32'hF);
        check("rst/pass", 32'(conflict_pass), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_check("solved", solved_b, 0, 0, zero_b);

        part_b = zero_b;
        part_b[0][1] = 4'd4; part_b[0][4] = 4'd5; part_b[0][6] = 4'd3; part_b[0][8] = 4'd1;
        part_b[1][0] = 4'd6; part_b[4][4] = 4'd9; part_b[8][8] = 4'd2;
        run_check("partial", part_b, 0, 0, zero_b);

        b = zero_b; b[0][0] = 4'd4; b[0][1] = 4'd4;
        run_check("dup_row", b, 0, 0, zero_b);

        b = zero_b; b[0][0] = 4'd5; b[4][0] = 4'd5;
        run_check("dup_col", b, 0, 0, zero_b);

        b = zero_b; b[0][0] = 4'd7; b[1][1] = 4'd7;
        run_check("dup_box", b, 0, 0, zero_b);

        b = zero_b; b[2][3] = 4'd12;
        run_check("illegal", b, 0, 0, zero_b);

        // Bus changes to a conflicting grid mid-scan: snapshot must win.
        b = solved_b; b[3][3] = b[3][4];
        run_check("bus_change", solved_b, 0, 20, b);

        // Start pulsed while busy must be ignored.
        run_check("start_busy", b, 50, 0, zero_b);

        // Reset in the middle of a scan.
        @(negedge clock);
        game_board = solved_b;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/done", 32'(done), 32'd0);
        check("abort/valid", 32'(valid), 32'd0);
        check("abort/complete", 32'(complete), 32'd0);
        check("abort/row", 32'(conflict_row), 32'hF);
        check("abort/col", 32'(conflict_col), 32'hF);
        check("abort/pass", 32'(conflict_pass), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("abort/no_done", 32'(saw_done), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_check("restart", solved_b, 0, 0, zero_b);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
